// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes, baud divider helper.
// No logic of its own; used by the transmitter now and the receiver later.
// Optional build macro UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_e;

   typedef struct packed {
      logic [31:0] div;
      logic [31:0] cnt_w;
   } baud_cfg_t;

   // Clocks per bit (truncating divide) and the counter width needed to hold 0..div-1.
   function automatic baud_cfg_t baud_cfg(input int clk_freq, input int baud);
      baud_cfg_t c;
      int        div;
      div     = clk_freq / baud;
      c.div   = 32'(div);
      c.cnt_w = (div > 1) ? 32'($clog2(div)) : 32'd1;
      return c;
   endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Ready/valid payload channel into the UART transmitter.
// Transfer happens on a clock edge with tx_valid && tx_ready both high.
// Source holds tx_data stable only while waiting for tx_ready.
interface uart_tx_param_if #(
   parameter int DATA_BITS = 8
) ();

   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled, ticks on the last count.
// Tick is combinational from the count, so each period is exactly BAUD_DIV cycles.
// No backpressure; clr_i wins over en_i and restarts the period.
module uart_baud_gen #(
   parameter int BAUD_DIV = 10,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = en_i && !clr_i && (cnt_q == LAST);

   // Next count: clear, hold when idle, otherwise wrap at the end of the bit period.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB first, optional parity, STOP_BITS stops.
// Line is registered; the start bit appears the cycle after the accepting edge.
// tx_ready is high only in IDLE, so a source waits a full frame; parity needs UART_TX_PARITY_EN.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int PARITY    = 0
) (
   input  logic               clk,
   input  logic               rst,
   uart_tx_param_if.slave     s_if,
   output logic               tx,
   output logic               busy
);

   localparam baud_cfg_t CFG      = baud_cfg(CLK_FREQ, BAUD);
   localparam int        BAUD_DIV = int'(CFG.div);
   localparam int        CNT_W    = int'(CFG.cnt_w);
   localparam int        BIT_W    = $clog2(DATA_BITS + 1);

   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   // Reject configurations the frame logic cannot represent.
   if (BAUD_DIV < 2) begin : g_bad_div
      $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_param: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end
   if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
   end

   uart_state_e          state_q;
   uart_state_e          state_d;
   logic [BIT_W-1:0]     bit_cnt_q;
   logic [BIT_W-1:0]     bit_cnt_d;
   logic [DATA_BITS-1:0] data_q;
   logic [DATA_BITS-1:0] data_d;
   logic                 tx_q;
   logic                 tx_d;
   logic                 hs;
   logic                 tick;
   logic                 baud_en;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_ON = (PARITY != PAR_NONE);
   logic par_bit;
   // Even mode makes the total count of ones even; odd mode inverts that.
   assign par_bit = (PARITY == PAR_EVEN) ? ^data_q : ~(^data_q);
`endif

   // Ready is masked during reset so nothing is accepted while the block is held.
   assign s_if.tx_ready = (state_q == ST_IDLE) && !rst;
   assign hs            = s_if.tx_valid && s_if.tx_ready;
   assign baud_en       = (state_q != ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign tx            = tx_q;

   uart_baud_gen #(
      .BAUD_DIV (BAUD_DIV),
      .CNT_W    (CNT_W)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (hs),
      .en_i   (baud_en),
      .tick_o (tick)
   );

   // Frame sequencing, then the line level for whichever state is entered next.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      tx_d      = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               state_d   = ST_START;
               data_d    = s_if.tx_data;
               bit_cnt_d = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = PAR_ON ? ST_PARITY : ST_STOP;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_d   = ST_STOP;
               bit_cnt_d = '0;
            end
         end
`endif
         ST_STOP: begin
            // bit_cnt doubles as the stop-bit counter.
            if (tick) begin
               if (bit_cnt_q == LAST_STOP) begin
                  state_d   = ST_IDLE;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
         end
      endcase

      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA: begin
            for (int i = 0; i < DATA_BITS; i++) begin
               if (bit_cnt_d == BIT_W'(i)) begin
                  tx_d = data_d[i];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = par_bit;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   // State, counters, payload and line register; reset forces the line idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         data_q    <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         tx_q      <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (8N1, 8E1, 5O2, 8O1) at 10 clocks per bit.
// A per-instance line monitor checks every cycle of each frame against a model.
// Parity expectations follow UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_param;

   localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
   localparam int PEN = 1;
`else
   localparam int PEN = 0;
`endif
   localparam int DB[4] = '{8, 8, 5, 8};
   localparam int SB[4] = '{1, 1, 2, 1};
   localparam int PM[4] = '{0, 2, 1, 1};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_w[4];
   logic       busy_w[4];
   logic       rdy_w[4];
   logic       vld_r[4];
   logic [8:0] dat_r[4];

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         frames[4];
   logic [8:0] exp_q[4][$];
   int         start_q[4][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_param_if #(.DATA_BITS(8)) if0 ();
   uart_tx_param_if #(.DATA_BITS(8)) if1 ();
   uart_tx_param_if #(.DATA_BITS(5)) if2 ();
   uart_tx_param_if #(.DATA_BITS(8)) if3 ();

   assign if0.tx_valid = vld_r[0];  assign if0.tx_data = dat_r[0][7:0];  assign rdy_w[0] = if0.tx_ready;
   assign if1.tx_valid = vld_r[1];  assign if1.tx_data = dat_r[1][7:0];  assign rdy_w[1] = if1.tx_ready;
   assign if2.tx_valid = vld_r[2];  assign if2.tx_data = dat_r[2][4:0];  assign rdy_w[2] = if2.tx_ready;
   assign if3.tx_valid = vld_r[3];  assign if3.tx_data = dat_r[3][7:0];  assign rdy_w[3] = if3.tx_ready;

   uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0))
      u0 (.clk(clk), .rst(rst), .s_if(if0.slave), .tx(tx_w[0]), .busy(busy_w[0]));
   uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2))
      u1 (.clk(clk), .rst(rst), .s_if(if1.slave), .tx(tx_w[1]), .busy(busy_w[1]));
   uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(5), .STOP_BITS(2), .PARITY(1))
      u2 (.clk(clk), .rst(rst), .s_if(if2.slave), .tx(tx_w[2]), .busy(busy_w[2]));
   uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1))
      u3 (.clk(clk), .rst(rst), .s_if(if3.slave), .tx(tx_w[3]), .busy(busy_w[3]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
      end
   endtask

   // Expected line level for bit slot b of a frame (0 = start bit).
   function automatic logic exp_level(input int db, input int pm, input logic [8:0] d, input int b);
      logic [8:0] m;
      logic       p;
      m = d & ((9'h1 << db) - 9'h1);
      p = ^m;
      if (pm == 1) p = ~p;
      if (b == 0) return 1'b0;
      if (b <= db) return d[b-1];
      if (PEN != 0 && pm != 0 && b == db + 1) return p;
      return 1'b1;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_mon
      logic [8:0] d;
      logic       e;
      int         nb, bad, bad_hs;
      bit         aborted;
      initial begin
         frames[g] = 0;
         forever begin
            @(negedge clk);
            if (!rst && tx_w[g] === 1'b0) begin
               start_q[g].push_back(cyc);
               if (exp_q[g].size() == 0) begin
                  chk($sformatf("u%0d unexpected frame", g), 1, 0);
               end else begin
                  d = exp_q[g].pop_front();
                  nb = 1 + DB[g] + ((PEN != 0 && PM[g] != 0) ? 1 : 0) + SB[g];
                  aborted = 0;
                  bad_hs = 0;
                  for (int b = 0; b < nb && !aborted; b++) begin
                     e = exp_level(DB[g], PM[g], d, b);
                     bad = 0;
                     for (int c = 0; c < DIV && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst) aborted = 1;
                        else begin
                           if (tx_w[g] !== e) bad++;
                           if (busy_w[g] !== 1'b1 || rdy_w[g] !== 1'b0) bad_hs++;
                        end
                     end
                     if (!aborted) chk($sformatf("u%0d data %0h slot %0d bad cycles", g, d, b), bad, 0);
                  end
                  if (!aborted) begin
                     chk($sformatf("u%0d data %0h busy/ready bad cycles", g, d), bad_hs, 0);
                     @(negedge clk);
                     chk($sformatf("u%0d first idle {ready,busy,tx}", g),
                         {29'd0, rdy_w[g], busy_w[g], tx_w[g]}, 32'h5);
                     frames[g]++;
                  end
               end
            end
         end
      end
   end

   // Offer one payload, record the expectation when it will be taken, return ready-low cycles.
   task automatic send(input int g, input logic [8:0] d, output int len);
      int w;
      @(negedge clk);
      vld_r[g] = 1'b1;
      dat_r[g] = d;
      w = 0;
      while (rdy_w[g] !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
      chk($sformatf("u%0d accept timeout", g), (w >= 2000) ? 1 : 0, 0);
      exp_q[g].push_back(d);
      @(posedge clk); #1;
      vld_r[g] = 1'b0;
      dat_r[g] = ~d;
      len = 0;
      while (len < 2000) begin
         @(negedge clk);
         if (rdy_w[g] === 1'b1) break;
         len++;
      end
   endtask

   typedef struct {
      int         g;
      logic [8:0] d;
      int         len;
   } vec_t;

   initial begin
      vec_t tv[6];
      int   len, f0, s1, s2, w;

      for (int i = 0; i < 4; i++) begin vld_r[i] = 1'b0; dat_r[i] = '0; end
      tv[0] = '{0, 9'h055, 100};
      tv[1] = '{1, 9'h0A3, 10 * (10 + PEN)};
      tv[2] = '{3, 9'h0A3, 10 * (10 + PEN)};
      tv[3] = '{2, 9'h01B, 10 * (8 + PEN)};
      tv[4] = '{0, 9'h0FF, 100};
      tv[5] = '{2, 9'h004, 10 * (8 + PEN)};

      repeat (3) @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("u%0d tx in reset", g), tx_w[g], 1);
         chk($sformatf("u%0d busy in reset", g), busy_w[g], 0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("u%0d tx after reset", g), tx_w[g], 1);
         chk($sformatf("u%0d busy after reset", g), busy_w[g], 0);
         chk($sformatf("u%0d ready after reset", g), rdy_w[g], 1);
      end

      for (int i = 0; i < 6; i++) begin
         send(tv[i].g, tv[i].d, len);
         chk($sformatf("vec%0d ready-low cycles", i), len, tv[i].len);
      end

      // Back-to-back with valid held: 0x12 then 0x34.
      start_q[0].delete();
      @(negedge clk);
      vld_r[0] = 1'b1; dat_r[0] = 9'h012;
      w = 0;
      while (rdy_w[0] !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
      exp_q[0].push_back(9'h012);
      @(posedge clk); #1;
      dat_r[0] = 9'h034;
      @(negedge clk);
      while (rdy_w[0] !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
      chk("b2b accept timeout", (w >= 2000) ? 1 : 0, 0);
      exp_q[0].push_back(9'h034);
      @(posedge clk); #1;
      vld_r[0] = 1'b0;
      repeat (110) @(negedge clk);
      chk("b2b start count", start_q[0].size(), 2);
      if (start_q[0].size() == 2) begin
         s1 = start_q[0][0];
         s2 = start_q[0][1];
         chk("b2b start after stop begin", s2 - (s1 + 90), 11);
      end

      // Payload changes after acceptance and valid while busy must not disturb the frame.
      f0 = frames[0];
      @(negedge clk);
      vld_r[0] = 1'b1; dat_r[0] = 9'h0F0;
      w = 0;
      while (rdy_w[0] !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
      exp_q[0].push_back(9'h0F0);
      @(posedge clk); #1;
      vld_r[0] = 1'b0; dat_r[0] = 9'h00F;
      repeat (20) @(negedge clk);
      vld_r[0] = 1'b1;
      repeat (30) @(negedge clk);
      vld_r[0] = 1'b0;
      repeat (200) @(negedge clk);
      chk("busy-valid frames sent", frames[0] - f0, 1);
      chk("busy-valid pending", exp_q[0].size(), 0);

      // Reset during data bit 3, then a clean frame.
      @(negedge clk);
      vld_r[0] = 1'b1; dat_r[0] = 9'h0C6;
      w = 0;
      while (rdy_w[0] !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
      exp_q[0].push_back(9'h0C6);
      @(posedge clk); #1;
      vld_r[0] = 1'b0;
      repeat (44) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid-frame reset tx", tx_w[0], 1);
      chk("mid-frame reset busy", busy_w[0], 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_q[0].delete();
      send(0, 9'h081, len);
      chk("post-reset 0x81 ready-low cycles", len, 100);

      repeat (20) @(negedge clk);
      for (int g = 0; g < 4; g++) chk($sformatf("u%0d leftover expectations", g), exp_q[g].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
